imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single combinational imem read port between the pipeline fetch stage (IF) and a debug/loader reader (DBG).
//  Fixed priority to IF with a starvation bound for DBG; read data is registered, so responses arrive 1 cycle after grant.
//  Sits between the fetch stage / debug unit and imem; imem itself is unchanged.
// PARAMETERS
//  N          32  instruction/data width
//  AW         7   imem address width
//  STARVE_MAX 4   max consecutive IF-won conflicts before DBG is forced through (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  if_req     in   1   IF read request; if_addr held stable until if_gnt
//  if_addr    in   AW  IF word address
//  if_gnt     out  1   IF request accepted this cycle (combinational)
//  if_rvalid  out  1   IF response valid (one-cycle pulse, no backpressure)
//  if_rdata   out  N   IF instruction word
//  dbg_req    in   1   DBG read request; dbg_addr held stable until dbg_gnt
//  dbg_addr   in   AW  DBG word address
//  dbg_gnt    out  1   DBG request accepted this cycle (combinational)
//  dbg_rvalid out  1   DBG response valid; held until dbg_rready
//  dbg_rdata  out  N   DBG read word; stable while dbg_rvalid && !dbg_rready
//  dbg_rready in   1   DBG consumes response
//  mem_addr   out  AW  to imem addr
//  mem_q      in   N   from imem q
// BEHAVIOUR
//  - Reset values: if_rvalid=0, dbg_rvalid=0, if_rdata=0, dbg_rdata=0, starve_cnt=0. Grants are combinational, so they are 0 whenever no req.
//  - dbg_ok = !dbg_rvalid || dbg_rready. Same-cycle drain plus new grant is allowed.
//  - Arbitration, per cycle:
//    - if_req only -> IF.
//    - dbg_req && dbg_ok only -> DBG.
//    - Both (dbg_ok) and starve_cnt < STARVE_MAX -> IF; starve_cnt++.
//    - Both (dbg_ok) and starve_cnt == STARVE_MAX -> DBG; if_gnt=0.
//    - starve_cnt clears on every DBG grant and whenever dbg_req=0. It never exceeds STARVE_MAX.
//    - dbg_req with !dbg_ok -> not a conflict; starve_cnt unchanged.
//  - mem_addr = granted requester's address; if_addr when no grant (keeps fetch path short).
//  - Latency: grant in cycle t -> rvalid/rdata in t+1, capturing mem_q at end of t.
//  - IF: back-to-back grants give one response per cycle; if_rdata keeps its last value when if_rvalid=0.
//  - DBG: at most one outstanding response. dbg_rvalid falls after the rready handshake unless a new DBG grant lands that same cycle.
//  - Reset mid-operation: pending responses are dropped, no rvalid after deassertion until a new grant.
//  - Full AW range is valid (2^AW words); no address wrap or range error.
// CONFIGURATION
//  IMEM_ARB_PERF_EN defined: adds outputs perf_if_cnt, perf_dbg_cnt, perf_conflict_cnt (16b each).
//    - Counters are saturating; reset to 0.
//    - Increment on IF grant, DBG grant, and cycle where both requested with dbg_ok.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  imem_arb_pkg: typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_DBG} gnt_e; PERF_W=16 constant.
//  Sub-module imem_arb_sel: combinational grant select, from (if_req, dbg_req, dbg_ok, starve_cnt) to gnt_e.
//  Top holds starve_cnt, response registers and optional perf counters.
// TESTING (current program image: word0=32'hf8000001, word1=32'hf8008002, word3=32'h8b050083)
//  1 Reset, then if_req with addr 0,1,3 over three consecutive cycles -> if_gnt=1 each cycle.
//    if_rvalid in cycles 2..4 with f8000001, f8008002, 8b050083.
//  2 dbg_req addr 1 alone, dbg_rready=0 for 3 cycles -> dbg_rvalid held, dbg_rdata=f8008002.
//    A second dbg_req is not granted until the cycle rready=1.
//  3 Both requesting continuously, STARVE_MAX=4, dbg_rready=1 -> grant pattern IF,IF,IF,IF,DBG repeating.
//    if_gnt=0 on each DBG cycle.
//  4 dbg_req drops after 2 conflicts, then reasserts -> starve_cnt restarts at 0.
//    DBG waits 4 more IF-won conflicts.
//  5 Assert reset in the cycle after a DBG grant -> dbg_rvalid=0 immediately, no late response after release.
//  6 IMEM_ARB_PERF_EN: scenario 3 for 10 cycles -> perf_if_cnt=8, perf_dbg_cnt=2, perf_conflict_cnt=10.
//    Preload counters near 16'hFFFF -> counters stick at FFFF.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the imem read-port arbiter.
// Optional perf counters are enabled by IMEM_ARB_PERF_EN.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_DBG
    } gnt_e;

    localparam int PERF_W = 16;

    // Counter width able to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/imem_arb_sel.sv
// Combinational grant select: fixed priority to IF, DBG forced through once
// IF has won STARVE_MAX consecutive conflicts.
module imem_arb_sel
    import imem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic          if_req,
    input  logic          dbg_req,
    input  logic          dbg_ok,
    input  logic [CW-1:0] starve_cnt,
    output gnt_e          gnt
);

    logic conflict;
    logic starved;

    assign conflict = if_req && dbg_req && dbg_ok;
    assign starved  = (starve_cnt >= CW'(STARVE_MAX));

    always_comb begin
        gnt = GNT_NONE;
        if (conflict) begin
            gnt = starved ? GNT_DBG : GNT_IF;
        end else if (if_req) begin
            gnt = GNT_IF;
        end else if (dbg_req && dbg_ok) begin
            gnt = GNT_DBG;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the imem read port between fetch (IF) and debug (DBG) with registered responses.
// Define IMEM_ARB_PERF_EN to add saturating grant/conflict perf counters.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int N          = 32,
    parameter int AW         = 7,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [N-1:0]  if_rdata,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [N-1:0]  dbg_rdata,
    input  logic          dbg_rready,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_q
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_if_cnt,
    output logic [PERF_W-1:0] perf_dbg_cnt,
    output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

    localparam int CW = cnt_width(STARVE_MAX);

    logic          dbg_ok;
    logic          conflict;
    logic [CW-1:0] starve_cnt;
    gnt_e          gnt;

    // A held DBG response may drain in the same cycle a new DBG grant lands.
    assign dbg_ok   = !dbg_rvalid || dbg_rready;
    assign conflict = if_req && dbg_req && dbg_ok;

    imem_arb_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CW         (CW)
    ) u_sel (
        .if_req     (if_req),
        .dbg_req    (dbg_req),
        .dbg_ok     (dbg_ok),
        .starve_cnt (starve_cnt),
        .gnt        (gnt)
    );

    assign if_gnt   = (gnt == GNT_IF);
    assign dbg_gnt  = (gnt == GNT_DBG);
    // Default to the fetch address so the IF path never waits on the select.
    assign mem_addr = dbg_gnt ? dbg_addr : if_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            starve_cnt <= '0;
        end else if (conflict) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
        end else begin
            if_rvalid <= if_gnt;
            if (if_gnt) begin
                if_rdata <= mem_q;
            end
        end
    end

    // DBG holds its response until the handshake; a same-cycle grant reloads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else if (dbg_gnt) begin
            dbg_rvalid <= 1'b1;
            dbg_rdata  <= mem_q;
        end else if (dbg_rready) begin
            dbg_rvalid <= 1'b0;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_if_cnt       <= '0;
            perf_dbg_cnt      <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (if_gnt && (perf_if_cnt != '1)) begin
                perf_if_cnt <= perf_if_cnt + PERF_W'(1);
            end
            if (dbg_gnt && (perf_dbg_cnt != '1)) begin
                perf_dbg_cnt <= perf_dbg_cnt + PERF_W'(1);
            end
            if (conflict && (perf_conflict_cnt != '1)) begin
                perf_conflict_cnt <= perf_conflict_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a response scoreboard and a small imem model.
// Perf counter checks are included when IMEM_ARB_PERF_EN is defined.
module tb_imem_arbiter;

    localparam int N  = 32;
    localparam int AW = 7;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [N-1:0]  if_rdata;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [N-1:0]  dbg_rdata;
    logic          dbg_rready;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_q;
`ifdef IMEM_ARB_PERF_EN
    logic [15:0]   perf_if_cnt;
    logic [15:0]   perf_dbg_cnt;
    logic [15:0]   perf_conflict_cnt;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t        ifQ[$];
    rsp_t        dbgQ[$];
    logic [31:0] mem[128];
    logic [31:0] lastIfData;
    int          cycle = 0;
    int          checkCount = 0;
    int          passCount = 0;
    int          failCount = 0;

    imem_arbiter #(
        .N          (N),
        .AW         (AW),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_rready (dbg_rready),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q)
`ifdef IMEM_ARB_PERF_EN
        ,
        .perf_if_cnt       (perf_if_cnt),
        .perf_dbg_cnt      (perf_dbg_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    assign mem_q = mem[mem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // One cycle: drive requests, check the combinational grant and address, and queue the expected response.
    task automatic applyStimulus(input logic ifReq, input logic [AW-1:0] ifAddr,
                                 input logic dbgReq, input logic [AW-1:0] dbgAddr,
                                 input logic rready, input logic expIf, input logic expDbg);
        rsp_t r;
        @(posedge clk);
        #1;
        if_req     = ifReq;
        if_addr    = ifAddr;
        dbg_req    = dbgReq;
        dbg_addr   = dbgAddr;
        dbg_rready = rready;
        #3;
        checkOutput("if_gnt", 32'(if_gnt), 32'(expIf));
        checkOutput("dbg_gnt", 32'(dbg_gnt), 32'(expDbg));
        checkOutput("mem_addr", 32'(mem_addr), 32'(expDbg ? dbgAddr : ifAddr));
        r.cyc = cycle + 1;
        if (expIf) begin
            r.data = mem[ifAddr];
            ifQ.push_back(r);
        end
        if (expDbg) begin
            r.data = mem[dbgAddr];
            dbgQ.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        if_req     = 1'b0;
        dbg_req    = 1'b0;
        dbg_rready = 1'b0;
        ifQ.delete();
        dbgQ.delete();
        lastIfData = '0;
        #1;
        checkOutput("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        checkOutput("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_dbg_rdata", dbg_rdata, 32'd0);
        checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Response monitor: compares DUT responses against the scoreboard each cycle.
    always @(negedge clk) begin
        if (!reset) begin
            rsp_t r;
            logic expIfValid;
            logic expDbgValid;
            expIfValid = (ifQ.size() > 0) && (ifQ[0].cyc == cycle);
            checkOutput("if_rvalid", 32'(if_rvalid), 32'(expIfValid));
            if (expIfValid) begin
                r = ifQ.pop_front();
                checkOutput("if_rdata", if_rdata, r.data);
                lastIfData = r.data;
            end else begin
                checkOutput("if_rdata_hold", if_rdata, lastIfData);
            end
            expDbgValid = (dbgQ.size() > 0) && (dbgQ[0].cyc <= cycle);
            checkOutput("dbg_rvalid", 32'(dbg_rvalid), 32'(expDbgValid));
            if (expDbgValid) begin
                checkOutput("dbg_rdata", dbg_rdata, dbgQ[0].data);
                if (dbg_rready) begin
                    r = dbgQ.pop_front();
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        end
        mem[0] = 32'hf8000001;
        mem[1] = 32'hf8008002;
        mem[3] = 32'h8b050083;
        lastIfData = '0;
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        dbg_req    = 1'b0;
        dbg_addr   = '0;
        dbg_rready = 1'b0;

        $display("[TB] reset and back-to-back fetch");
        doReset();
        applyStimulus(1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd3, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
        idle(2);

        $display("[TB] debug read held without rready");
        applyStimulus(1'b0, 7'd0, 1'b1, 7'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 7'd0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 7'd5, 1'b1, 7'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 7'd0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 7'd0, 1'b1, 7'd3, 1'b1, 1'b0, 1'b1);
        idle(2);

        $display("[TB] continuous conflict starvation pattern");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 7'(i), 1'b1, 7'(100 + i), 1'b1, (i % 5) != 4, (i % 5) == 4);
        end
        idle(2);

        $display("[TB] dbg_req drop clears starvation count");
        applyStimulus(1'b1, 7'd10, 1'b1, 7'd40, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd11, 1'b1, 7'd40, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 7'd12, 1'b0, 7'd40, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 7'(13 + i), 1'b1, 7'd41, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 7'd17, 1'b1, 7'd41, 1'b1, 1'b0, 1'b1);
        idle(2);

        $display("[TB] reset after debug grant");
        applyStimulus(1'b0, 7'd0, 1'b1, 7'd3, 1'b0, 1'b0, 1'b1);
        doReset();
        idle(3);

`ifdef IMEM_ARB_PERF_EN
        $display("[TB] perf counters");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 7'(i), 1'b1, 7'(60 + i), 1'b1, (i % 5) != 4, (i % 5) == 4);
        end
        idle(1);
        checkOutput("perf_if_cnt", 32'(perf_if_cnt), 32'd8);
        checkOutput("perf_dbg_cnt", 32'(perf_dbg_cnt), 32'd2);
        checkOutput("perf_conflict_cnt", 32'(perf_conflict_cnt), 32'd10);
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 7'(i), 1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
        end
        idle(1);
        checkOutput("perf_if_sat", 32'(perf_if_cnt), 32'h0000ffff);
        checkOutput("perf_dbg_hold", 32'(perf_dbg_cnt), 32'd2);
        checkOutput("perf_conflict_hold", 32'(perf_conflict_cnt), 32'd10);
`endif

        idle(2);
        checkOutput("ifq_drained", 32'(ifQ.size()), 32'd0);
        checkOutput("dbgq_drained", 32'(dbgQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
